// File: rtl/jstk_pkg.sv
// Shared constants for the PmodJSTK SPI master: command prefix, FSM encoding
// and the position of each payload byte within a transaction.
package jstk_pkg;

   localparam logic [5:0] CMD_PREFIX = 6'b100000;
   localparam int         NBYTES     = 5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_XFER  = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [2:0] XL  = 3'd0;
   localparam logic [2:0] XH  = 3'd1;
   localparam logic [2:0] YL  = 3'd2;
   localparam logic [2:0] YH  = 3'd3;
   localparam logic [2:0] BTN = 3'd4;

   function automatic logic [7:0] cmd_byte(input logic [1:0] led);
      return {CMD_PREFIX, led};
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the divided SPI square wave, plus registered
// rise/fall strobes that appear three clk cycles after the pad transition.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_pad,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_pad;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/jstk_spi_master.sv
// Mode-0 SPI master for the PmodJSTK: one 5-byte exchange per start request,
// sending the LED command and decoding X, Y and button state on completion.
module jstk_spi_master #(
   parameter int PRE_EDGES = 2,
   parameter int GAP_EDGES = 1,
   parameter int NBYTES    = jstk_pkg::NBYTES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_in,
   input  logic       start,
   input  logic [1:0] led,
   input  logic       miso,
   output logic       sck,
   output logic       mosi,
   output logic       ss_n,
   output logic       busy,
   output logic       done,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic [2:0] buttons
);

   import jstk_pkg::*;

   localparam logic [3:0] PRE_LAST  = (PRE_EDGES > 1) ? 4'(PRE_EDGES - 1) : 4'd0;
   localparam logic [3:0] GAP_LAST  = (GAP_EDGES > 1) ? 4'(GAP_EDGES - 1) : 4'd0;
   localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

   logic       w_level;
   logic       w_rise;
   logic       w_fall;

   logic [2:0] r_state;
   logic [3:0] r_edge_cnt;
   logic [3:0] r_bit_cnt;
   logic [2:0] r_byte_idx;
   logic [7:0] r_tx_shift;
   logic [7:0] r_rx_shift;
   logic [7:0] r_slot_xl;
   logic [1:0] r_slot_xh;
   logic [7:0] r_slot_yl;
   logic [1:0] r_slot_yh;
   logic       r_sck;
   logic       r_mosi;
   logic       r_ss_n;
   logic       r_busy;
   logic       r_done;
   logic [9:0] r_x_pos;
   logic [9:0] r_y_pos;
   logic [2:0] r_buttons;

   edge_sync u_edge_sync (
      .clk     (clk),
      .rst     (rst),
      .i_pad   (sclk_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_edge_cnt <= 4'd0;
         r_bit_cnt  <= 4'd0;
         r_byte_idx <= 3'd0;
         r_tx_shift <= 8'h00;
         r_rx_shift <= 8'h00;
         r_slot_xl  <= 8'h00;
         r_slot_xh  <= 2'b00;
         r_slot_yl  <= 8'h00;
         r_slot_yh  <= 2'b00;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
         r_ss_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_x_pos    <= 10'd0;
         r_y_pos    <= 10'd0;
         r_buttons  <= 3'd0;
      end else begin
         r_done <= 1'b0;
         // The synchronised level only reaches the pin while bits are moving.
         r_sck  <= (r_state == ST_XFER) ? w_level : 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_SETUP;
                  r_busy     <= 1'b1;
                  r_ss_n     <= 1'b0;
                  r_edge_cnt <= 4'd0;
                  r_bit_cnt  <= 4'd0;
                  r_byte_idx <= 3'd0;
                  r_tx_shift <= cmd_byte(led);
               end
            end

            ST_SETUP: begin
               if (w_fall) begin
                  if (r_edge_cnt == PRE_LAST) begin
                     r_state    <= ST_XFER;
                     r_mosi     <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end else begin
                     r_edge_cnt <= r_edge_cnt + 4'd1;
                  end
               end
            end

            ST_XFER: begin
               if (w_rise) begin
                  r_rx_shift <= {r_rx_shift[6:0], miso};
                  r_bit_cnt  <= r_bit_cnt + 4'd1;
               end else if (w_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     r_bit_cnt  <= 4'd0;
                     r_edge_cnt <= 4'd0;
                     // Only the bits that survive output decode are kept per slot.
                     case (r_byte_idx)
                        XL:      r_slot_xl <= r_rx_shift;
                        XH:      r_slot_xh <= r_rx_shift[1:0];
                        YL:      r_slot_yl <= r_rx_shift;
                        YH:      r_slot_yh <= r_rx_shift[1:0];
                        default: ;
                     endcase
                     if (r_byte_idx == LAST_BYTE) begin
                        r_state   <= ST_DONE;
                        r_ss_n    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_x_pos   <= {r_slot_xh, r_slot_xl};
                        r_y_pos   <= {r_slot_yh, r_slot_yl};
                        r_buttons <= r_rx_shift[2:0];
                     end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_mosi     <= 1'b0;
                        r_tx_shift <= 8'h00;
                        if (GAP_EDGES != 0) begin
                           r_state <= ST_GAP;
                        end
                     end
                  end else begin
                     r_mosi     <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end
               end
            end

            ST_GAP: begin
               if (w_fall) begin
                  if (r_edge_cnt == GAP_LAST) begin
                     r_state    <= ST_XFER;
                     r_mosi     <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end else begin
                     r_edge_cnt <= r_edge_cnt + 4'd1;
                  end
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sck     = r_sck;
   assign mosi    = r_mosi;
   assign ss_n    = r_ss_n;
   assign busy    = r_busy;
   assign done    = r_done;
   assign x_pos   = r_x_pos;
   assign y_pos   = r_y_pos;
   assign buttons = r_buttons;

endmodule

// File: tb/tb_jstk_spi_master.sv
// Bench for jstk_spi_master: a joystick slave model, a fast sclk_in source and
// a byte-level reference for MOSI content, decoded outputs and bit timing.
module tb_jstk_spi_master;

   localparam int H   = 8;
   localparam int P   = 2 * H;
   localparam int PRE = 2;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk_in = 1'b0;
   logic       start = 1'b0;
   logic [1:0] led = 2'b00;
   logic       miso = 1'b0;
   logic       sck;
   logic       mosi;
   logic       ss_n;
   logic       busy;
   logic       done;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic [2:0] buttons;

   jstk_spi_master #(
      .PRE_EDGES (PRE),
      .GAP_EDGES (GAP),
      .NBYTES    (5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sclk_in (sclk_in),
      .start   (start),
      .led     (led),
      .miso    (miso),
      .sck     (sck),
      .mosi    (mosi),
      .ss_n    (ss_n),
      .busy    (busy),
      .done    (done),
      .x_pos   (x_pos),
      .y_pos   (y_pos),
      .buttons (buttons)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // sclk_in source; freeze holds the current level
   bit freeze = 1'b0;
   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         if (!freeze) begin
            if (div == H - 1) begin
               div = 0;
               sclk_in = ~sclk_in;
            end else begin
               div++;
            end
         end
      end
   end

   // joystick slave plus bus monitor
   logic [39:0] slave_data = 40'h0;
   logic [39:0] slave_shift = 40'h0;
   logic [39:0] mosi_cap = 40'h0;
   int cyc = 0;
   int ss_falls = 0;
   int dones = 0;
   int rises = 0;
   int unstable = 0;
   int sck_bad = 0;
   int ss_fall_cyc = 0;
   int last_mosi_cyc = 0;
   int rise_q[$];

   initial begin
      logic p_sck, p_ss, p_mosi;
      p_sck = 1'b0; p_ss = 1'b1; p_mosi = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mosi !== p_mosi) last_mosi_cyc = cyc;
         if (p_ss && !ss_n) begin
            ss_falls++;
            ss_fall_cyc = cyc;
            rises = 0;
            unstable = 0;
            rise_q.delete();
            mosi_cap = 40'h0;
            slave_shift = slave_data;
            miso = slave_shift[39];
         end
         if (!p_sck && sck) begin
            rises++;
            rise_q.push_back(cyc);
            mosi_cap = {mosi_cap[38:0], mosi};
            if (cyc - last_mosi_cyc < 2) unstable++;
         end
         if (p_sck && !sck && !ss_n) begin
            slave_shift = {slave_shift[38:0], 1'b0};
            miso = slave_shift[39];
         end
         if (sck && ss_n) sck_bad++;
         if (done) dones++;
         p_sck = sck;
         p_ss = ss_n;
         p_mosi = mosi;
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("idle_tmo", 64'(busy), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (!done && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done_tmo"}, 64'(done), 64'd1);
   endtask

   task automatic check_results(input string tag, input logic [1:0] l, input logic [39:0] data);
      int b[5];
      int ex, ey, eb;
      logic [7:0] cmd;
      for (int k = 0; k < 5; k++) b[k] = int'(data[39 - 8*k -: 8]);
      ex = (b[1] % 4) * 256 + b[0];
      ey = (b[3] % 4) * 256 + b[2];
      eb = b[4] % 8;
      cmd = 8'(128 + int'(l));
      check({tag, "_x"}, 64'(x_pos), 64'(ex));
      check({tag, "_y"}, 64'(y_pos), 64'(ey));
      check({tag, "_btn"}, 64'(buttons), 64'(eb));
      check({tag, "_mosi"}, 64'(mosi_cap), {24'h0, cmd, 32'h0});
      check({tag, "_rises"}, 64'(rises), 64'd40);
      check({tag, "_mosi_stable"}, 64'(unstable), 64'd0);
      $display("txn %s led=%b data=%h -> x=%h y=%h btn=%b", tag, l, data, x_pos, y_pos, buttons);
   endtask

   task automatic run_txn(input string tag, input logic [1:0] l, input logic [39:0] data,
                          input bit timing, input bit do_freeze);
      int d0, sf0, r0, t, bad;
      slave_data = data;
      led = l;
      wait_idle();
      // launch just after a sclk_in rise so the setup window covers two full periods
      @(posedge sclk_in);
      @(negedge clk);
      d0 = dones;
      sf0 = ss_falls;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (do_freeze) begin
         t = 0;
         while (!(ss_falls != sf0 && rises >= 20) && t < 5000) begin
            @(negedge clk);
            t++;
         end
         t = 0;
         do begin
            @(posedge clk);
            t++;
         end while (!sclk_in && t < 100);
         freeze = 1'b1;
         r0 = rises;
         repeat (10000) @(negedge clk);
         check({tag, "_frz_ssn"}, 64'(ss_n), 64'd0);
         check({tag, "_frz_busy"}, 64'(busy), 64'd1);
         check({tag, "_frz_rises"}, 64'(rises), 64'(r0));
         check({tag, "_frz_done"}, 64'(dones), 64'(d0));
         freeze = 1'b0;
      end
      wait_done(tag);
      repeat (3) @(negedge clk);
      check({tag, "_done_once"}, 64'(dones - d0), 64'd1);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check_results(tag, l, data);
      if (timing && rise_q.size() == 40) begin
         bad = 0;
         for (int k = 1; k < 40; k++) begin
            if (rise_q[k] - rise_q[k-1] != ((k % 8 == 0) ? P * (1 + GAP) : P)) bad++;
         end
         check({tag, "_intervals"}, 64'(bad), 64'd0);
         check({tag, "_setup_2per"}, 64'(rise_q[0] - ss_fall_cyc >= 2 * P), 64'd1);
      end
   endtask

   initial begin
      logic [39:0] d;
      int t;
      int d0, sf0;

      // reset state
      repeat (4) @(negedge clk);
      check("rst_sck", 64'(sck), 64'd0);
      check("rst_mosi", 64'(mosi), 64'd0);
      check("rst_ssn", 64'(ss_n), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_outs", 64'({x_pos, y_pos, buttons}), 64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // reset in the middle of a transfer
      slave_data = 40'h77_03_66_02_07;
      led = 2'b01;
      sf0 = ss_falls;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!(ss_falls != sf0 && rises >= 12) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("midrst_reach12", 64'(rises >= 12), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_ssn", 64'(ss_n), 64'd1);
      check("midrst_sck", 64'(sck), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_x", 64'(x_pos), 64'd0);
      $display("txn midrst: reset after %0d rises", rises);

      // directed transaction with full timing checks
      run_txn("fixed", 2'b11, 40'h34_02_A5_01_05, 1'b1, 1'b0);
      run_txn("allff", 2'b00, 40'hFF_FF_FF_FF_FF, 1'b1, 1'b0);

      for (int i = 0; i < 5; i++) begin
         d = {$urandom, 8'($urandom)};
         run_txn($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), d, 1'b1, 1'b0);
      end

      // start held high throughout: one transaction, next one accepted right after DONE
      d = {$urandom, 8'($urandom)};
      slave_data = d;
      led = 2'b10;
      wait_idle();
      d0 = dones;
      sf0 = ss_falls;
      start = 1'b1;
      @(negedge clk);
      wait_done("spam1");
      check("spam_one_txn", 64'(ss_falls - sf0), 64'd1);
      check_results("spam1", 2'b10, d);
      @(negedge clk);
      check("spam_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("spam_reaccept", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done("spam2");
      repeat (3) @(negedge clk);
      check("spam_two_txn", 64'(ss_falls - sf0), 64'd2);
      check("spam_dones", 64'(dones - d0), 64'd2);
      check_results("spam2", 2'b10, d);

      // sclk_in frozen high mid-transfer
      run_txn("freeze", 2'b01, 40'h5A_01_C3_02_06, 1'b0, 1'b1);

      check("sck_outside_ss", 64'(sck_bad), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jstk_spi_master.md
Name: jstk_spi_master

Overview:
- SPI master for the PmodJSTK joystick.
- Consumes the 66.67 kHz square wave from the system clock divider and runs a complete 5-byte joystick transaction for each start request.
- Each transaction sends the LED command byte and captures X, Y and button state.
- Sits between the divider and the tank-control logic, which reads the decoded position registers.

Parameters:
- PRE_EDGES, 2: sclk_in falling edges waited after ss_n falls before the first bit (at least 15 us at 66.67 kHz).
- GAP_EDGES, 1: sclk_in falling edges idled between bytes.
- NBYTES, 5: bytes per transaction; fixed by the PmodJSTK protocol.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- sclk_in  in  1  divided square wave from the divider; sampled in the clk domain.
- start  in  1  one-cycle request; ignored unless busy=0.
- led  in  2  LED state loaded into the command byte when start is accepted.
- miso  in  1  joystick data out.
- sck  out  1  SPI clock to the joystick.
- mosi  out  1  SPI data to the joystick.
- ss_n  out  1  slave select, active low.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the results update.
- x_pos  out  10  X position.
- y_pos  out  10  Y position.
- buttons  out  3  {btn2, btn1, joystick press}.

Behaviour:
- Reset values (asynchronous): sck=0, mosi=0, ss_n=1, busy=0, done=0, x_pos=0, y_pos=0, buttons=0, FSM in IDLE.
- sclk_in passes through a 2-flop synchroniser followed by an edge register.
  - rise/fall are one-cycle strobes, 3 clk cycles after the pad transition.
- SPI mode 0 (CPOL=0, CPHA=0).
  - In XFER, sck is the registered synchronised sclk_in; elsewhere sck=0.
  - MISO is sampled on rise; MOSI shifts on fall, MSB first.
- Command byte: {6'b100000, led}, captured at start. Bytes 2-5 send 8'h00.
- FSM states and transitions:
  - IDLE: ss_n=1. start → SETUP; busy=1, ss_n=0 on the next cycle, edge counter cleared.
  - SETUP: count fall strobes. At the PRE_EDGES-th fall → XFER, with MOSI driven with bit7 of the current byte in the same cycle.
  - XFER: each rise shifts miso into the RX shift register and increments the bit count.
    - A fall after 1-7 rises puts the next bit on MOSI.
    - The fall after the 8th rise stores the RX byte into byte slot [byte_idx].
    - If byte_idx = NBYTES-1 → DONE; else → GAP.
  - GAP: sck=0; count GAP_EDGES falls → XFER with the next byte's MSB on MOSI. GAP_EDGES=0 skips GAP.
  - DONE: for one cycle, ss_n=1, busy=0, done=1 and the outputs update. → IDLE.
- Output decode:
  - x_pos = {byte1[1:0], byte0}.
  - y_pos = {byte3[1:0], byte2}.
  - buttons = byte4[2:0].
- x_pos, y_pos and buttons change only in the DONE cycle and hold between transactions.
- A start while busy=1 is dropped; it is neither queued nor an error.
- start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- If rst asserts mid-transaction: all outputs take their reset values asynchronously, ss_n=1, and partial bytes are discarded.
- If sclk_in stops, the FSM holds its state indefinitely; there is no timeout.
- Counter widths: bit count 4 bits (0-8), byte index 3 bits, edge counter 4 bits. Defaults are bounded by these widths; PRE_EDGES and GAP_EDGES must be at most 15.

Decomposition:
- Shared package jstk_pkg holds:
  - CMD_PREFIX = 6'b100000, NBYTES = 5.
  - The FSM state encoding (IDLE, SETUP, XFER, GAP, DONE).
  - Byte index constants (XL=0, XH=1, YL=2, YH=3, BTN=4).
- One sub-module is natural: edge_sync (2-flop synchroniser plus rise/fall strobes).
- The byte shifter stays inline.

Test Plan:
- Reset mid-XFER (assert rst after the 12th rise) → ss_n=1, sck=0, busy=0 immediately; x_pos is unchanged from the prior value of 0; the next start completes normally.
- led=2'b11, start, model returns 8'h34,8'h02,8'hA5,8'h01,8'h05 → MOSI bytes 8'h83,00,00,00,00; x_pos=10'h234, y_pos=10'h1A5, buttons=3'b101; done pulses once.
- Timing check, same transaction → exactly 40 sck rises while ss_n=0; MOSI stable on every sck rise; ss_n falls at least 2 sclk_in periods before the first sck rise; sck=0 in SETUP and GAP.
- start asserted every cycle during a transaction → exactly one transaction; the second transaction starts in the first IDLE cycle after done.
- Model returns 8'hFF for all bytes → x_pos=10'h3FF, y_pos=10'h3FF, buttons=3'b111 (upper byte bits masked).
- sclk_in frozen high during XFER for 10k clk cycles → state, ss_n=0 and busy=1 held; completes correctly after sclk_in resumes.
